// File: rtl/mac_skew_feeder.sv
// Operand tile buffer for a systolic MAC array: stores a DIM x DIM tile and
// streams it out with row i delayed by i beats, so each array row sees its data skewed.
module mac_skew_feeder #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   WrEn,
  input  logic [$clog2(DIM)-1:0]                 Arow,
  input  logic signed [DIM-1:0][BITS_AB-1:0]     Ain,
  input  logic                                   start,
  output logic signed [DIM-1:0][BITS_AB-1:0]     Aout,
  output logic                                   out_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int KW = $clog2(2 * DIM);
  localparam logic [KW-1:0] LAST_BEAT = KW'(2 * DIM - 2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state;
  logic [KW-1:0]             k;
  logic [BITS_AB-1:0]        mem [DIM][DIM];
  logic [DIM-1:0][BITS_AB-1:0] skew;

  // Row i shows column k-i on beat k; beats outside the row's window are zero.
  always_comb begin
    skew = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (k == KW'(i + j)) skew[i] = mem[i][j];
      end
    end
  end

  assign busy = (state == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      Aout      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) mem[i][j] <= '0;
      end
    end else begin
      // Row writes are accepted only while idle, regardless of en.
      if (state == IDLE && WrEn) begin
        for (int j = 0; j < DIM; j++) mem[Arow][j] <= Ain[j];
      end
      if (en) begin
        case (state)
          IDLE: begin
            Aout      <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            if (start) begin
              state <= STREAM;
              k     <= '0;
            end
          end
          STREAM: begin
            Aout      <= skew;
            out_valid <= 1'b1;
            if (k == LAST_BEAT) begin
              state <= IDLE;
              done  <= 1'b1;
              k     <= '0;
            end else begin
              done <= 1'b0;
              k    <= k + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Directed self-checking bench for mac_skew_feeder at DIM=4, BITS_AB=8.
module tb_mac_skew_feeder;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             WrEn;
  logic [1:0]       Arow;
  logic [3:0][7:0]  Ain;
  logic             start;
  logic [3:0][7:0]  Aout;
  logic             out_valid;
  logic             busy;
  logic             done;

  int compared   = 0;
  int mismatched = 0;

  mac_skew_feeder #(.DIM(4), .BITS_AB(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
    .start(start), .Aout(Aout), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] row, input logic [31:0] data,
                               input logic st);
    WrEn  = wr;
    Arow  = row;
    Ain   = data;
    start = st;
    tick();
    WrEn  = 1'b0;
    start = 1'b0;
  endtask

  // Tile 0: all zero; tile 1: mem[i][j]=16i+j; tile 2: tile 1 with row 1 all 0x80.
  function automatic logic [31:0] expBeat(input int k, input int tile);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = k - i;
      if (d >= 0 && d <= 3) begin
        if (tile == 0)                r[i*8 +: 8] = 8'h00;
        else if (tile == 2 && i == 1) r[i*8 +: 8] = 8'h80;
        else                          r[i*8 +: 8] = 8'(16 * i + d);
      end
    end
    return r;
  endfunction

  task automatic expectBeat(input string tag, input int k, input int tile);
    checkOutput({tag, "_aout"}, Aout, expBeat(k, tile));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_done"}, 32'(done), (k == 6) ? 32'd1 : 32'd0);
  endtask

  // Streams one tile after start; optional stall after stallAt and write/start noise.
  task automatic runStream(input string tag, input int tile, input int stallAt, input bit noisy);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
    checkOutput({tag, "_valid_start"}, 32'(out_valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      if (noisy) begin
        WrEn = 1'b1; Arow = 2'd0; Ain = 32'h7F7F7F7F; start = 1'b1;
      end
      tick();
      if (noisy) begin
        WrEn = 1'b0; start = 1'b0;
      end
      expectBeat($sformatf("%s_b%0d", tag, k), k, tile);
      if (k == stallAt) begin
        en = 1'b0;
        for (int s = 0; s < 2; s++) begin
          tick();
          expectBeat($sformatf("%s_stall%0d", tag, s), k, tile);
        end
        en = 1'b1;
      end
      if (tile == 1 && k == 3) checkOutput({tag, "_b3_const"}, Aout, 32'h30211203);
      if (tile == 1 && k == 6) checkOutput({tag, "_b6_const"}, Aout, 32'h33000000);
    end
    tick();
    checkOutput({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; WrEn = 1'b1; Arow = 2'd2; Ain = 32'hDEADBEEF; start = 1'b1;
    #1;
    checkOutput("rst_aout", Aout, 32'h0);
    tick(); tick();
    checkOutput("rst_aout2", Aout, 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    WrEn = 1'b0; start = 1'b0;
    rst_n = 1'b1;
    tick();

    runStream("zero", 0, -1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)}, 1'b0);
    end
    runStream("basic", 1, -1, 1'b0);
    runStream("stall", 1, 2, 1'b0);
    runStream("wrblock", 1, -1, 1'b1);
    runStream("again", 1, -1, 1'b0);

    // Row write coincident with start must be visible to the stream it starts.
    WrEn = 1'b1; Arow = 2'd1; Ain = 32'h80808080; start = 1'b1;
    tick();
    WrEn = 1'b0; start = 1'b0;
    checkOutput("simul_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      expectBeat($sformatf("simul_b%0d", k), k, 2);
      if (k == 1) checkOutput("simul_b1_row1", 32'(Aout[1]), 32'h80);
    end
    tick();

    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    expectBeat("abort_b4", 4, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_aout", Aout, 32'h0);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    runStream("postabort", 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
